// File: rtl/hex_scan_driver_if.sv
// Display-side bundle for hex_scan_driver: the word and blanking control
// coming from the display mux, and the segment/anode/frame outputs going
// to the board pins.
interface hex_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] HexDisplay32Bits;
  logic                Blank_Leading;
  logic [6:0]          Segments;
  logic [DIGITS-1:0]   Digit_Enable;
  logic                Frame_Done;

  modport master (
    output HexDisplay32Bits, Blank_Leading,
    input  Segments, Digit_Enable, Frame_Done
  );

  modport slave (
    input  HexDisplay32Bits, Blank_Leading,
    output Segments, Digit_Enable, Frame_Done
  );
endinterface

// File: rtl/hex_scan_driver.sv
// Time-multiplexed driver for a bank of common-anode 7-segment digits.
// A shadow copy of the input word is taken only at frame boundaries so a
// frame never mixes two words. Each digit slot starts with one all-off
// cycle to avoid ghosting while the anode select moves.
module hex_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  hex_scan_driver_if.slave  disp
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WORD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(DIGITS - 1);

  // Active-low hex glyphs, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0]  c_q, c_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [WORD_W-1:0] s_q, s_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic              fd_q, fd_d;

  logic              tick;
  logic              frame_end;
  logic              upper_zero;
  logic [3:0]        cur_nib;

  // Next-state for scan position, shadow word and registered pin outputs.
  always_comb begin
    tick       = (c_q == C_LAST);
    frame_end  = tick && (i_q == I_LAST);
    c_d        = tick ? '0 : c_q + 1'b1;
    i_d        = i_q;
    if (tick) begin
      i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
    end
    s_d        = frame_end ? disp.HexDisplay32Bits : s_q;
    fd_d       = frame_end;

    // A digit is a leading zero when it and every more significant nibble
    // are zero; digit 0 always stays lit so a zero word still shows "0".
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((k >= int'(i_q)) && (s_q[4*k +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    cur_nib    = 4'(s_q >> (4 * i_q));

    if (disp.Blank_Leading && (i_q != '0) && upper_zero) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = hex_glyph(cur_nib);
    end

    // First cycle of every slot keeps all anodes off.
    en_d = (c_q == '0) ? '1 : ~(DIGITS'(1) << i_q);
  end

  // State and output registers; reset aborts the scan immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      c_q   <= '0;
      i_q   <= '0;
      s_q   <= '0;
      seg_q <= 7'h7F;
      en_q  <= '1;
      fd_q  <= 1'b0;
    end else begin
      c_q   <= c_d;
      i_q   <= i_d;
      s_q   <= s_d;
      seg_q <= seg_d;
      en_q  <= en_d;
      fd_q  <= fd_d;
    end
  end

  assign disp.Segments     = seg_q;
  assign disp.Digit_Enable = en_q;
  assign disp.Frame_Done   = fd_q;

endmodule
